uart_rx: RTL

//  - 8N1 UART receiver, LSB first, 1 start bit, 1 stop bit, no parity; counterpart of uart_tx.
//  - Bit period is CLOCK_DIV+1 clocks, identical to uart_tx at the same CLOCK_DIV.
//  - Samples the asynchronous serial line and presents each received byte with a one-cycle valid pulse.
//  - Sits between the external RX pin and the core command/data path.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encodings, data width and default divider.
// Also provides the 2-of-3 vote used when UART_RX_MAJORITY_EN is defined.
package uart_rx_pkg;

  localparam int unsigned UART_DATA_W       = 8;
  localparam int unsigned CLOCK_DIV_DEFAULT = 104;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } uart_state_e;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input; both flops reset to 1 (idle line level).
module uart_rx_sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, bit period CLOCK_DIV+1 clocks.
// Optional macro UART_RX_MAJORITY_EN: samples are a 2-of-3 vote over recent rx_s values.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLOCK_DIV = CLOCK_DIV_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] data_out,
  output logic                   valid,
  output logic                   busy,
  output logic                   frame_err
);

  localparam logic [15:0] MidCnt = 16'(CLOCK_DIV / 2);
  localparam logic [15:0] DivCnt = 16'(CLOCK_DIV);

  logic w_rx_s;
  logic w_sample;

  uart_rx_sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (w_rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Live rx_s plus two previous values form the 3-deep voting window.
  logic [1:0] r_hist;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rx_s};
    end
  end

  assign w_sample = maj3({r_hist, w_rx_s});
`else
  assign w_sample = w_rx_s;
`endif

  uart_state_e            r_state, w_state_next;
  logic [15:0]            r_count, w_count_next;
  logic [2:0]             r_bit_idx, w_bit_idx_next;
  logic [UART_DATA_W-1:0] r_shreg, w_shreg_next;
  logic [UART_DATA_W-1:0] r_data, w_data_next;
  logic                   r_valid, w_valid_next;
  logic                   r_ferr, w_ferr_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_bit_idx <= w_bit_idx_next;
      r_shreg   <= w_shreg_next;
      r_data    <= w_data_next;
      r_valid   <= w_valid_next;
      r_ferr    <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count + 16'd1;
    w_bit_idx_next = r_bit_idx;
    w_shreg_next   = r_shreg;
    w_data_next    = r_data;
    w_valid_next   = 1'b0;
    w_ferr_next    = r_ferr;
    unique case (r_state)
      StIdle: begin
        w_count_next = '0;
        if (!w_rx_s) w_state_next = StStart;
      end
      StStart: begin
        if (r_count == MidCnt) begin
          w_count_next   = '0;
          w_bit_idx_next = '0;
          w_state_next   = w_sample ? StIdle : StData;
        end
      end
      StData: begin
        if (r_count == DivCnt) begin
          w_count_next            = '0;
          w_shreg_next[r_bit_idx] = w_sample;
          if (r_bit_idx == 3'd7) begin
            w_state_next = StStop;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
      StStop: begin
        if (r_count == DivCnt) begin
          w_count_next = '0;
          if (w_sample) begin
            w_data_next  = r_shreg;
            w_valid_next = 1'b1;
            w_ferr_next  = 1'b0;
            w_state_next = StIdle;
          end else begin
            w_ferr_next  = 1'b1;
            w_state_next = StBreak;
          end
        end
      end
      StBreak: begin
        // Wait out a held-low line so it cannot look like a new start bit.
        w_count_next = '0;
        if (w_rx_s) w_state_next = StIdle;
      end
      default: begin
        w_count_next = '0;
        w_state_next = StIdle;
      end
    endcase
  end

  assign data_out  = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  // State is already IDLE during the valid cycle; hold busy through it.
  assign busy      = (r_state != StIdle) || r_valid;

endmodule
